// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Circular instruction queue between fetch and dual-issue decode.
//            Accepts up to two instructions per cycle and presents the two
//            oldest entries show-ahead. It stalls the PC when fewer than two
//            entries are free, and it is emptied on recovery flush.
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_instr0,
  input  logic [31:0]                fetch_instr1,
  input  logic                       fetch_instr1_valid,
  input  logic                       fetch_pred_taken,
  input  logic                       fetch_pred_slot,
  output logic                       fetch_stall,
  output logic                       dec_valid0,
  output logic                       dec_valid1,
  output logic [31:0]                dec_pc0,
  output logic [31:0]                dec_pc1,
  output logic [31:0]                dec_instr0,
  output logic [31:0]                dec_instr1,
  output logic                       dec_pred_taken0,
  output logic                       dec_pred_taken1,
  input  logic [1:0]                 dec_pop,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_STALL_LEVEL = CW'(DEPTH - 1);
  localparam logic [CW-1:0] c_TWO         = CW'(2);

  // Entry storage (not reset; validity comes from the occupancy counter)
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          pt_mem_q    [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          w_push0;
  logic          w_push1;
  logic [CW-1:0] w_push_n;
  logic [CW-1:0] w_pop_req;
  logic [CW-1:0] w_pop_n;
  logic [AW-1:0] w_tail1;
  logic [AW-1:0] w_head1;

  // Stall depends only on the registered count so the PC path starts at a flop
  assign fetch_stall = (count_q >= c_STALL_LEVEL);

  assign w_push0  = fetch_valid & ~fetch_stall & ~flush;
  // Slot 1 is dropped when slot 0 is a predicted-taken branch
  assign w_push1  = w_push0 & fetch_instr1_valid & ~(fetch_pred_taken & ~fetch_pred_slot);
  assign w_push_n = CW'(w_push0) + CW'(w_push1);

  // Decode asking for more than is present is clamped to the occupancy
  assign w_pop_req = CW'(dec_pop);
  assign w_pop_n   = (w_pop_req > count_q) ? count_q : w_pop_req;

  assign w_tail1 = tail_q + AW'(1);
  assign w_head1 = head_q + AW'(1);

  // Next-state pointer and occupancy arithmetic; flush discards this cycle's push/pop
  always_comb begin
    head_d  = head_q + AW'(w_pop_n);
    tail_d  = tail_q + AW'(w_push_n);
    count_d = count_q + w_push_n - w_pop_n;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write accepted slots at tail and tail+1 (wraps naturally modulo DEPTH)
  always_ff @(posedge clk) begin
    if (w_push0) begin
      pc_mem_q[tail_q]    <= fetch_pc;
      instr_mem_q[tail_q] <= fetch_instr0;
      pt_mem_q[tail_q]    <= fetch_pred_taken & ~fetch_pred_slot;
    end
    if (w_push1) begin
      pc_mem_q[w_tail1]    <= fetch_pc + 32'd4;
      instr_mem_q[w_tail1] <= fetch_instr1;
      pt_mem_q[w_tail1]    <= fetch_pred_taken & fetch_pred_slot;
    end
  end

  assign dec_valid0      = (count_q != '0);
  assign dec_valid1      = (count_q >= c_TWO);
  assign dec_pc0         = pc_mem_q[head_q];
  assign dec_pc1         = pc_mem_q[w_head1];
  assign dec_instr0      = instr_mem_q[head_q];
  assign dec_instr1      = instr_mem_q[w_head1];
  assign dec_pred_taken0 = pt_mem_q[head_q];
  assign dec_pred_taken1 = pt_mem_q[w_head1];
  assign count           = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed plus random stimulus for fetch_queue, compared each
//            cycle against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr0;
  logic [31:0] fetch_instr1;
  logic        fetch_instr1_valid;
  logic        fetch_pred_taken;
  logic        fetch_pred_slot;
  logic        fetch_stall;
  logic        dec_valid0;
  logic        dec_valid1;
  logic [31:0] dec_pc0;
  logic [31:0] dec_pc1;
  logic [31:0] dec_instr0;
  logic [31:0] dec_instr1;
  logic        dec_pred_taken0;
  logic        dec_pred_taken1;
  logic [1:0]  dec_pop;
  logic [$clog2(DEPTH):0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
  } entry_t;

  entry_t mq[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .fetch_valid        (fetch_valid),
    .fetch_pc           (fetch_pc),
    .fetch_instr0       (fetch_instr0),
    .fetch_instr1       (fetch_instr1),
    .fetch_instr1_valid (fetch_instr1_valid),
    .fetch_pred_taken   (fetch_pred_taken),
    .fetch_pred_slot    (fetch_pred_slot),
    .fetch_stall        (fetch_stall),
    .dec_valid0         (dec_valid0),
    .dec_valid1         (dec_valid1),
    .dec_pc0            (dec_pc0),
    .dec_pc1            (dec_pc1),
    .dec_instr0         (dec_instr0),
    .dec_instr1         (dec_instr1),
    .dec_pred_taken0    (dec_pred_taken0),
    .dec_pred_taken1    (dec_pred_taken1),
    .dec_pop            (dec_pop),
    .count              (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic i1v, input logic pt,
                       input logic ps, input logic [1:0] pop, input logic fl);
    fetch_valid        = fv;
    fetch_pc           = pc;
    fetch_instr0       = i0;
    fetch_instr1       = i1;
    fetch_instr1_valid = i1v;
    fetch_pred_taken   = pt;
    fetch_pred_slot    = ps;
    dec_pop            = pop;
    flush              = fl;
  endtask

  // One clock: advance the model by the queue rules, then compare all outputs
  task automatic cyc();
    int     p;
    bit     stall;
    entry_t e;
    stall = (DEPTH - mq.size()) < 2;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      p = (int'(dec_pop) > mq.size()) ? mq.size() : int'(dec_pop);
      repeat (p) void'(mq.pop_front());
      if (fetch_valid && !stall) begin
        e.pc = fetch_pc; e.instr = fetch_instr0;
        e.pt = fetch_pred_taken && (fetch_pred_slot == 1'b0);
        mq.push_back(e);
        if (fetch_instr1_valid && !(fetch_pred_taken && fetch_pred_slot == 1'b0)) begin
          e.pc = fetch_pc + 32'd4; e.instr = fetch_instr1;
          e.pt = fetch_pred_taken && (fetch_pred_slot == 1'b1);
          mq.push_back(e);
        end
      end
    end
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("valid0", 32'(dec_valid0), 32'(mq.size() >= 1));
    chk("valid1", 32'(dec_valid1), 32'(mq.size() >= 2));
    chk("stall", 32'(fetch_stall), 32'((DEPTH - mq.size()) < 2));
    if (mq.size() >= 1) begin
      chk("pc0", dec_pc0, mq[0].pc);
      chk("instr0", dec_instr0, mq[0].instr);
      chk("pt0", 32'(dec_pred_taken0), 32'(mq[0].pt));
    end
    if (mq.size() >= 2) begin
      chk("pc1", dec_pc1, mq[1].pc);
      chk("instr1", dec_instr1, mq[1].instr);
      chk("pt1", 32'(dec_pred_taken1), 32'(mq[1].pt));
    end
  endtask

  initial begin
    logic [31:0] spc;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid0", 32'(dec_valid0), 32'd0);
    chk("reset_stall", 32'(fetch_stall), 32'd0);
    rst = 1'b0;

    // Basic pair push
    drive(1, 32'h100, 32'hA, 32'hB, 1, 0, 0, 0, 0); cyc();
    chk("pair_count", 32'(count), 32'd2);
    chk("pair_pc0", dec_pc0, 32'h100);
    chk("pair_pc1", dec_pc1, 32'h104);
    chk("pair_i0", dec_instr0, 32'hA);
    chk("pair_i1", dec_instr1, 32'hB);

    // Line-crossing fetch then pair
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    drive(1, 32'h1C, 32'h11, 32'h12, 0, 0, 0, 0, 0); cyc();
    drive(1, 32'h20, 32'h13, 32'h14, 1, 0, 0, 0, 0); cyc();
    chk("lx_count", 32'(count), 32'd3);
    chk("lx_pc0", dec_pc0, 32'h1C);
    chk("lx_pc1", dec_pc1, 32'h20);

    // Predicted-taken slot 0 then slot 1
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    drive(1, 32'h40, 32'h21, 32'h22, 1, 1, 0, 0, 0); cyc();
    chk("pt0_count", 32'(count), 32'd1);
    chk("pt0_taken", 32'(dec_pred_taken0), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    drive(1, 32'h40, 32'h21, 32'h22, 1, 1, 1, 0, 0); cyc();
    chk("pt1_count", 32'(count), 32'd2);
    chk("pt1_taken0", 32'(dec_pred_taken0), 32'd0);
    chk("pt1_taken1", 32'(dec_pred_taken1), 32'd1);

    // Fill to DEPTH, stall, then drain two
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(8 * i), 32'(i), 32'(i + 100), 1, 0, 0, 0, 0); cyc();
    end
    chk("fill_count6", 32'(count), 32'd6);
    chk("fill_stall6", 32'(fetch_stall), 32'd0);
    drive(1, 32'h218, 32'h3, 32'h103, 1, 0, 0, 0, 0); cyc();
    chk("fill_count8", 32'(count), 32'd8);
    chk("fill_stall8", 32'(fetch_stall), 32'd1);
    drive(1, 32'h300, 32'h55, 32'h56, 1, 0, 0, 0, 0); cyc();
    chk("fill_ignored", 32'(count), 32'd8);
    drive(1, 32'h300, 32'h55, 32'h56, 1, 0, 0, 2, 0); cyc();
    chk("drain_count", 32'(count), 32'd6);
    chk("drain_stall", 32'(fetch_stall), 32'd0);

    // Steady two-in/two-out across pointer wrap
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    spc = 32'h1000;
    drive(1, spc, spc, spc + 1, 1, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 20; i++) begin
      spc = spc + 32'd8;
      drive(1, spc, spc, spc + 1, 1, 0, 0, 2, 0); cyc();
      chk("steady_count", 32'(count), 32'd2);
      chk("steady_pc0", dec_pc0, spc);
    end

    // Flush at count 5 with fetch and pop active
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    drive(1, 32'h500, 1, 2, 1, 0, 0, 0, 0); cyc();
    drive(1, 32'h508, 3, 4, 1, 0, 0, 0, 0); cyc();
    drive(1, 32'h510, 5, 6, 0, 0, 0, 0, 0); cyc();
    chk("pre_flush_count", 32'(count), 32'd5);
    drive(1, 32'h600, 7, 8, 1, 0, 0, 2, 1); cyc();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid0", 32'(dec_valid0), 32'd0);
    chk("flush_stall", 32'(fetch_stall), 32'd0);
    drive(1, 32'h700, 9, 10, 1, 0, 0, 0, 0); cyc();
    chk("post_flush_pc0", dec_pc0, 32'h700);

    // Reset mid-stream
    rst = 1'b1; drive(1, 32'h800, 1, 2, 1, 0, 0, 1, 0); cyc();
    chk("rst_mid_count", 32'(count), 32'd0);
    rst = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            1'($urandom), 2'($urandom_range(0, 2)),
            $urandom_range(0, 39) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the I-cache/fetch stage and dual-issue decode. Each cycle it accepts up to two instructions fetched at the current PC (one when the fetch crosses an I-cache line or slot 0 is predicted taken) and presents up to two of the oldest instructions to decode with their PCs and prediction bits. It drives back-pressure to the program counter and is emptied on branch misprediction or store-set violation recovery.

## Interface
- DEPTH, 8: queue entries (one instruction each); power of two, ≥ 4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  recovery (exe_branch_PrMiss or store_set_violation); empties queue
- fetch_valid  in  1  I-cache data valid for fetch_pc
- fetch_pc  in  32  address of slot 0
- fetch_instr0  in  32  instruction at fetch_pc
- fetch_instr1  in  32  instruction at fetch_pc+4
- fetch_instr1_valid  in  1  slot 1 valid (0 on line-crossing fetch)
- fetch_pred_taken  in  1  BTB predicted a taken branch in this fetch group
- fetch_pred_slot  in  1  slot holding the predicted-taken branch
- fetch_stall  out  1  queue cannot accept a group; PC must hold
- dec_valid0 / dec_valid1  out  1  head / head+1 entry valid
- dec_pc0 / dec_pc1  out  32  PCs of head / head+1
- dec_instr0 / dec_instr1  out  32  instructions of head / head+1
- dec_pred_taken0 / dec_pred_taken1  out  1  entry was predicted taken
- dec_pop  in  2  entries consumed by decode this cycle (0, 1, 2)
- count  out  log2(DEPTH)+1  occupied entries

## Operation
- Circular buffer; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; separate occupancy counter.
- Push count n: 0 if !fetch_valid, fetch_stall or flush. Else slot 0 always pushed; slot 1 pushed iff fetch_instr1_valid && !(fetch_pred_taken && fetch_pred_slot==0). n ∈ {1,2}.
- Entry fields: pc, instr, pred_taken. Slot 0 pc = fetch_pc, slot 1 pc = fetch_pc+4 (32-bit wrap). pred_taken = fetch_pred_taken && (fetch_pred_slot == slot index). Slot-1 prediction with slot 1 not pushed is dropped.
- Slot 0 written at tail, slot 1 at tail+1 (mod DEPTH); tail += n.
- Pop: effective pop p = min(dec_pop, count); dec_pop > count is a protocol error, clamped. head += p.
- count_next = count + n − p; push and pop in the same cycle both take effect.
- fetch_stall = (DEPTH − count) < 2, from registered count only (no dependence on dec_pop), so an accepted group always fits.
- Outputs show-ahead: dec_valid0 = count≥1, dec_valid1 = count≥2; data read combinationally at head, head+1. Data on invalid slots is don't-care.
- Flush: next cycle head=tail=count=0; push and pop in the flush cycle discarded. Flush has priority over everything except rst.
- Reset: head=tail=count=0; dec_valid0/1=0; fetch_stall=0. Entry storage not reset.

## Timing
- Push-to-decode latency 1 cycle: group pushed at edge k visible on dec_* after edge k.
- Throughput 2 instr/cycle in and out; sustained when decode pops 2 each cycle.
- fetch_stall reflects count after the previous edge; combinational path fetch_stall→PC is from a flop only.
- Flush at edge k: dec_valid0=0 and fetch_stall=0 after edge k; first post-recovery group can be pushed at edge k+1.
- Wrap: tail/head crossing DEPTH−1→0 seamless, including a 2-entry push at tail=DEPTH−1 (slots at DEPTH−1 and 0).

## Test plan
- Reset, then push pc=0x100, instr0=0xA, instr1=0xB, instr1_valid=1, dec_pop=0 -> next cycle count=2, dec_pc0=0x100, dec_pc1=0x104, dec_instr0/1=0xA/0xB, both valid.
- Line-crossing fetch pc=0x1C, instr1_valid=0, then pc=0x20 pair -> entries 0x1C,0x20,0x24; count=3.
- Predicted taken slot 0 (fetch_pred_taken=1, slot=0) at pc=0x40 -> one entry, dec_pred_taken0=1, count=1; with slot=1 -> two entries, only dec_pred_taken1=1.
- Fill DEPTH=8 with dec_pop=0: after 3 pairs count=6 fetch_stall=0; 4th pair -> count=8, fetch_stall=1; further fetch_valid ignored; dec_pop=2 -> count=6, fetch_stall=0 next cycle.
- Steady push 2 / pop 2 for 20 cycles across wrap -> count constant 2, PCs strictly in fetch order, no loss.
- Flush with fetch_valid=1 and dec_pop=2 at count=5 -> next cycle count=0, dec_valid0=0, fetch_stall=0; rst mid-stream likewise clears queue.
